score_max_sub: RTL and testbench
================================

SCORE_MAX_SUB -- requirements
Module: score_max_sub

Interface
REQ-001 SHALL have parameter D_W, default 16, element width (signed two's complement).
REQ-002 SHALL have parameter DIM, default 16, elements per row; legal range 2..32.
REQ-003 SHALL have parameter SHIFT, default 2, right-shift amount used only when SCORE_SCALE_EN is defined.
REQ-004 SHALL have port I_CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port I_RST_N  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port I_START  input  1  level request, held high for the whole operation and while the result is consumed.
REQ-007 SHALL have port I_DATA  input  D_W*DIM  score row; element i at bits [D_W*i +: D_W].
REQ-008 SHALL have port O_VLD  output  1  result valid, level; directly drives the softmax stage's I_START.
REQ-009 SHALL have port O_DATA  output  D_W*DIM  row with its maximum subtracted; same element packing as I_DATA.

Function
REQ-010 SHALL implement one-hot states IDLE, MAX, SUB, DONE.
REQ-011 IDLE with I_START=1: SHALL capture I_DATA into an internal row register, clear O_DATA, cnt<=0, go to MAX; I_DATA may change afterwards.
REQ-012 MAX: SHALL scan one element per cycle, cnt 0..DIM-1; running max initialised from element 0 and replaced only on strictly greater signed value; at cnt=DIM-1 SHALL go to SUB with cnt<=0.
REQ-013 SUB: SHALL write one element per cycle, O_DATA[i] <= sat(row[i] - max); at cnt=DIM-1 SHALL go to DONE.
REQ-014 Subtraction SHALL be computed in D_W+1 bits and saturated to -2^(D_W-1); results are always <= 0, and the max element yields exactly 0.
REQ-015 Ties: every element equal to the max SHALL yield 0.
REQ-016 Latency: O_VLD SHALL rise on the clock edge 2*DIM after the edge sampling I_START in IDLE (DIM=16: 32 edges later).
REQ-017 DONE: SHALL hold O_VLD=1 and O_DATA stable while I_START=1; on I_START=0 go to IDLE with O_VLD<=0 and O_DATA retained.
REQ-018 I_START=0 in MAX or SUB (abort): next edge SHALL go to IDLE, clear cnt and running max, set O_DATA<=0 and O_VLD=0.
REQ-019 O_VLD SHALL be 0 in every state other than DONE.
REQ-020 A new row SHALL be accepted only after at least one IDLE cycle with I_START=0 following DONE.

Reset
REQ-021 I_RST_N low SHALL asynchronously force state=IDLE, O_VLD=0, O_DATA=0, cnt=0, running max=0, row register=0, including mid-operation.
REQ-022 After reset release, the first I_START=1 SHALL start a clean operation with no residue from the aborted row.

Configuration
REQ-023 Macro SCORE_SCALE_EN defined: each element SHALL be arithmetically right-shifted by SHIFT at capture, before the max scan (1/sqrt(d) scaling).
REQ-024 SCORE_SCALE_EN undefined: elements SHALL be captured unmodified, SHIFT unused; latency is identical in both builds.

Structure
REQ-025 Shared package mha_pkg SHALL hold default D_W, default DIM and the state encodings S_IDLE/S_MAX/S_SUB/S_DONE.
REQ-026 Combinational sub-module sat_sub (D_W-wide saturating signed subtract) SHALL be instantiated once and shared across SUB cycles.

Verification
REQ-027 DIM=4, D_W=16, no scale, row {5,-3,12,0}, I_START held -> O_VLD high 8 edges after sampling, O_DATA {-7,-15,0,-12}.
REQ-028 Row {-32768,32767,0,1} -> O_DATA {-32768(saturated),0,-32767,-32766}.
REQ-029 All-equal row {100,100,100,100} -> O_DATA all 0; repeat with row {-4,-4,-4,-4} -> all 0.
REQ-030 Drop I_START on 3rd MAX cycle -> next edge IDLE, O_VLD=0, O_DATA=0; restart with {1,2,3,4} -> {-3,-2,-1,0}.
REQ-031 Assert I_RST_N=0 mid-SUB (asynchronously, between edges) -> outputs zero immediately; next run is correct.
REQ-032 SCORE_SCALE_EN, SHIFT=2, row {16,-8,40,4} -> scaled {4,-2,10,1}, O_DATA {-6,-12,0,-9}.

Source files
------------

// File: rtl/mha_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mha_pkg
// Description : Shared definitions for the attention score pipeline.
//               Holds the default element width and row length, plus the
//               one-hot state encodings used by score_max_sub.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package mha_pkg;

  localparam int DEF_D_W = 16;   // default signed element width
  localparam int DEF_DIM = 16;   // default elements per score row

  // One-hot encodings: each state owns a single flop bit.
  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_MAX  = 4'b0010,
    S_SUB  = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

endpackage : mha_pkg
`default_nettype wire

// File: rtl/sat_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sat_sub
// Description : Combinational signed subtract y = sat(a - b).
//               The difference is formed one bit wider than the operands and
//               then clamped into the D_W-bit signed range.
// Ports       : a [D_W] - minuend   (signed two's complement)
//               b [D_W] - subtrahend (signed two's complement)
//               y [D_W] - saturated difference
// Revision    : 1.0 - initial release
// ============================================================================
module sat_sub #(
  parameter int D_W = 16
) (
  input  logic [D_W-1:0] a,
  input  logic [D_W-1:0] b,
  output logic [D_W-1:0] y
);

  logic signed [D_W:0] w_diff;

  assign w_diff = $signed({a[D_W-1], a}) - $signed({b[D_W-1], b});

  // The top two bits disagree only when the result left the D_W-bit range.
  always_comb begin
    y = w_diff[D_W-1:0];
    if (w_diff[D_W] != w_diff[D_W-1]) begin
      y = w_diff[D_W] ? {1'b1, {(D_W-1){1'b0}}} : {1'b0, {(D_W-1){1'b1}}};
    end
  end

endmodule : sat_sub
`default_nettype wire

// File: rtl/score_max_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : score_max_sub
// Description : Subtracts the row maximum from every element of a score row
//               ahead of the softmax stage. A row is captured when I_START is
//               seen in IDLE, scanned for its maximum one element per cycle,
//               then rewritten one element per cycle as sat(row[i] - max).
//               O_VLD is a level that is held in DONE until I_START drops.
//               Optional build macro SCORE_SCALE_EN: elements are arithmetically
//               right-shifted by SHIFT at capture (1/sqrt(d) scaling).
// Ports       : I_CLK   - clock, rising edge
//               I_RST_N - asynchronous active-low reset
//               I_START - level request, held for the whole operation
//               I_DATA  - score row, element i at [D_W*i +: D_W]
//               O_VLD   - result valid level (feeds softmax I_START)
//               O_DATA  - row minus its maximum, same packing as I_DATA
// Revision    : 1.0 - initial release
// ============================================================================
module score_max_sub
  import mha_pkg::*;
#(
  parameter int D_W   = DEF_D_W,
  parameter int DIM   = DEF_DIM,
  parameter int SHIFT = 2
) (
  input  logic               I_CLK,
  input  logic               I_RST_N,
  input  logic               I_START,
  input  logic [D_W*DIM-1:0] I_DATA,
  output logic               O_VLD,
  output logic [D_W*DIM-1:0] O_DATA
);

  localparam int CW = $clog2(DIM);
  localparam logic [CW-1:0] C_LAST = CW'(DIM - 1);

  // With scaling disabled the capture shift collapses to zero.
`ifdef SCORE_SCALE_EN
  localparam int C_SHIFT = SHIFT;
`else
  localparam int C_SHIFT = 0 * SHIFT;
`endif

  state_t                    state;
  state_t                    state_nxt;
  logic [DIM-1:0][D_W-1:0]   r_row;
  logic [DIM-1:0][D_W-1:0]   r_out;
  logic [DIM-1:0][D_W-1:0]   w_cap;
  logic [D_W-1:0]            r_max;
  logic [CW-1:0]             r_cnt;
  logic                      r_vld;
  logic [D_W-1:0]            w_elem;
  logic [D_W-1:0]            w_sub;
  logic                      w_last;

  // Capture path: unpack the input row and apply the optional scaling.
  for (genvar i = 0; i < DIM; i++) begin : g_cap
    assign w_cap[i] = $signed(I_DATA[D_W*i +: D_W]) >>> C_SHIFT;
  end

  assign w_elem = r_row[r_cnt];
  assign w_last = (r_cnt == C_LAST);

  // Single subtractor shared by every SUB cycle through the element mux.
  sat_sub #(
    .D_W (D_W)
  ) u_sat_sub (
    .a (w_elem),
    .b (r_max),
    .y (w_sub)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic; dropping I_START anywhere returns to IDLE.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (I_START) state_nxt = S_MAX;
      S_MAX: begin
        if (!I_START)    state_nxt = S_IDLE;
        else if (w_last) state_nxt = S_SUB;
      end
      S_SUB: begin
        if (!I_START)    state_nxt = S_IDLE;
        else if (w_last) state_nxt = S_DONE;
      end
      S_DONE: if (!I_START) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      r_row <= '0;
      r_out <= '0;
      r_max <= '0;
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (I_START) begin
            r_row <= w_cap;
            r_out <= '0;
            r_max <= '0;
            r_cnt <= '0;
          end
        end
        S_MAX: begin
          if (!I_START) begin
            r_out <= '0;
            r_max <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
          end else begin
            // Element 0 seeds the running max; later elements replace it
            // only when strictly greater, so ties keep the first one.
            if (r_cnt == '0 || $signed(w_elem) > $signed(r_max)) begin
              r_max <= w_elem;
            end
            r_cnt <= w_last ? '0 : r_cnt + CW'(1);
          end
        end
        S_SUB: begin
          if (!I_START) begin
            r_out <= '0;
            r_max <= '0;
            r_cnt <= '0;
            r_vld <= 1'b0;
          end else begin
            r_out[r_cnt] <= w_sub;
            if (w_last) begin
              r_cnt <= '0;
              r_vld <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          // Result stays on O_DATA after the handshake completes.
          if (!I_START) r_vld <= 1'b0;
        end
        default: begin
          r_vld <= 1'b0;
        end
      endcase
    end
  end

  assign O_VLD  = r_vld;
  assign O_DATA = r_out;

endmodule : score_max_sub
`default_nettype wire

// File: tb/tb_score_max_sub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_score_max_sub
// Description : Self-checking bench for score_max_sub with DIM=4, D_W=16.
//               Directed rows with hand-computed results are queued when
//               issued; a monitor pops and compares whenever O_VLD rises,
//               also checking result latency and hold stability.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_score_max_sub;

  localparam int D_W = 16;
  localparam int DIM = 4;
  localparam int LAT = 2 * DIM;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [D_W*DIM-1:0] din;
  logic               vld;
  logic [D_W*DIM-1:0] dout;

  typedef struct {
    logic [D_W*DIM-1:0] data;
    int                 start_edge;
    string              name;
  } exp_t;

  exp_t               sbq[$];
  int                 checks = 0;
  int                 errors = 0;
  int                 edge_cnt = 0;
  logic               prev_vld = 1'b0;
  logic [D_W*DIM-1:0] held = '0;
  string              held_name = "none";

  score_max_sub #(
    .D_W   (D_W),
    .DIM   (DIM),
    .SHIFT (2)
  ) dut (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .I_START (start),
    .I_DATA  (din),
    .O_VLD   (vld),
    .O_DATA  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [D_W*DIM-1:0] pk(input int a0, input int a1,
                                             input int a2, input int a3);
    return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: pop on each rising O_VLD, then check the held value.
  always @(negedge clk) begin
    exp_t cur;
    if (vld && !prev_vld) begin
      if (sbq.size() == 0) begin
        chk("unexpected_vld", 64'd1, 64'd0);
      end else begin
        cur = sbq.pop_front();
        chk({cur.name, "_data"}, dout, cur.data);
        chk({cur.name, "_latency"}, 64'(edge_cnt - cur.start_edge), 64'(LAT));
        held      = cur.data;
        held_name = cur.name;
      end
    end else if (vld) begin
      chk({held_name, "_hold"}, dout, held);
    end
    prev_vld = vld;
  end

  task automatic wait_vld(input string nm);
    int n = 0;
    while (!vld && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!vld) chk({nm, "_timeout"}, 64'd0, 64'd1);
  endtask

  // Issue one row, keep I_START high through DONE, then release it.
  task automatic run_row(input logic [63:0] row, input logic [63:0] exp,
                         input string nm);
    @(negedge clk);
    din   = row;
    start = 1'b1;
    sbq.push_back('{exp, edge_cnt + 1, nm});
    @(negedge clk);
    din = ~row;               // input may change once captured
    wait_vld(nm);
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk({nm, "_release_vld"}, 64'(vld), 64'd0);
    chk({nm, "_retained"}, dout, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    din   = '0;
    repeat (3) @(negedge clk);
    chk("reset_vld", 64'(vld), 64'd0);
    chk("reset_data", dout, 64'd0);
    rst_n = 1'b1;

    run_row(pk(5, -3, 12, 0),         pk(-7, -15, 0, -12),          "basic");
    run_row(pk(-32768, 32767, 0, 1),  pk(-32768, 0, -32767, -32766), "sat");
    run_row(pk(100, 100, 100, 100),   pk(0, 0, 0, 0),               "eq_pos");
    run_row(pk(-4, -4, -4, -4),       pk(0, 0, 0, 0),               "eq_neg");
    run_row(pk(3, 7, 7, -1),          pk(-4, 0, 0, -8),             "tie_mid");
    run_row(pk(-1, -2, -3, -100),     pk(0, -1, -2, -99),           "all_neg");

    // Abort on the third MAX cycle.
    @(negedge clk);
    din = pk(9, 8, 7, 6);
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_max_vld", 64'(vld), 64'd0);
    chk("abort_max_data", dout, 64'd0);
    run_row(pk(1, 2, 3, 4), pk(-3, -2, -1, 0), "after_abort_max");

    // Abort after two SUB writes: partial result visible, then cleared.
    @(negedge clk);
    din = pk(50, 60, 70, 80);
    start = 1'b1;
    repeat (7) @(negedge clk);
    chk("sub_partial", dout, pk(-30, -20, 0, 0));
    start = 1'b0;
    @(negedge clk);
    chk("abort_sub_vld", 64'(vld), 64'd0);
    chk("abort_sub_data", dout, 64'd0);

    // Asynchronous reset between edges in the middle of SUB.
    @(negedge clk);
    din = pk(1, 2, 3, 4);
    start = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    chk("async_rst_vld", 64'(vld), 64'd0);
    chk("async_rst_data", dout, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_row(pk(10, -20, 30, -40), pk(-20, -50, 0, -70), "after_reset");

`ifdef SCORE_SCALE_EN
    run_row(pk(16, -8, 40, 4), pk(-6, -12, 0, -9), "scale");
`else
    run_row(pk(16, -8, 40, 4), pk(-24, -48, 0, -36), "noscale");
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_score_max_sub
`default_nettype wire
